// File: rtl/lc3_sequencer.sv
// LC3 stage sequencer and fetch unit.
// Owns STAGE, IR, PC, the instruction-memory request/ack handshake with a
// fetch timeout, the data-memory writeback stall, the sticky halt/error
// flags and the retired-instruction counter. The control decoder sees STAGE
// and IR and steers this block through IR_LE, PC_LE, PC_CONTROL and the
// NEXT_STAGE override.
module lc3_sequencer #(
  parameter logic [15:0] RESET_PC      = 16'h3000,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter logic [15:0] HALT_OPCODE   = 16'hF025
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [15:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [15:0] IMEM_RDATA,
  input  logic        IR_LE,
  input  logic        PC_LE,
  input  logic        PC_CONTROL,
  input  logic [15:0] ALU_Y,
  input  logic        NEXT_STAGE_LE,
  input  logic [1:0]  NEXT_STAGE,
  input  logic        DMEM_BUSY,
  output logic [1:0]  STAGE,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic        HALTED,
  output logic        FETCH_ERR,
  output logic [15:0] INSTR_COUNT
);

  // Stage encoding is fixed by the control decoder's STAGE input.
  localparam logic [1:0] ST_DECODE    = 2'b00;
  localparam logic [1:0] ST_EXECUTE   = 2'b01;
  localparam logic [1:0] ST_WRITEBACK = 2'b10;
  localparam logic [1:0] ST_FETCH     = 2'b11;

  // A zero timeout disables the watchdog; the counter may then wrap freely
  // because nothing compares against it.
  localparam logic        TMO_EN    = (FETCH_TIMEOUT != 0);
  localparam logic [15:0] TMO_LIMIT = 16'(FETCH_TIMEOUT);

  logic [1:0]  stage_q, stage_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        halted_q, halted_d;
  logic        ferr_q, ferr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;

  // Per-cycle events shared by the next-state blocks below.
  logic        in_fetch, fetch_ack, fetch_wait, tmo_hit;
  logic        wb_leave, halt_retire, enter_fetch;
  logic [15:0] tmo_inc;

  // Classify this cycle: fetch handshake outcome, writeback exit, halt.
  always_comb begin
    in_fetch    = !halted_q && (stage_q == ST_FETCH);
    fetch_ack   = in_fetch && req_q && IMEM_ACK;
    fetch_wait  = in_fetch && req_q && !IMEM_ACK;
    tmo_inc     = tmo_q + 16'd1;
    tmo_hit     = fetch_wait && TMO_EN && (tmo_inc == TMO_LIMIT);
    wb_leave    = !halted_q && (stage_q == ST_WRITEBACK) && !DMEM_BUSY;
    halt_retire = wb_leave && (ir_q == HALT_OPCODE);
  end

  // Stage transitions. The halt opcode forces FETCH regardless of override;
  // DMEM_BUSY holds WRITEBACK ahead of any override.
  always_comb begin
    stage_d = stage_q;
    if (!halted_q) begin
      case (stage_q)
        ST_FETCH:     if (fetch_ack) stage_d = ST_DECODE;
        ST_DECODE:    stage_d = NEXT_STAGE_LE ? NEXT_STAGE : ST_EXECUTE;
        ST_EXECUTE:   stage_d = NEXT_STAGE_LE ? NEXT_STAGE : ST_WRITEBACK;
        ST_WRITEBACK: begin
          if (!DMEM_BUSY) begin
            if (ir_q == HALT_OPCODE) stage_d = ST_FETCH;
            else                     stage_d = NEXT_STAGE_LE ? NEXT_STAGE : ST_FETCH;
          end
        end
        default:      stage_d = stage_q;
      endcase
    end
    // Any arrival in FETCH from another stage retires an instruction.
    enter_fetch = !halted_q && (stage_q != ST_FETCH) && (stage_d == ST_FETCH);
  end

  // Fetch request and watchdog. REQ rises on the edge entering FETCH (or the
  // first edge out of reset) and drops on ACK or timeout.
  always_comb begin
    req_d = req_q;
    tmo_d = tmo_q;
    if (in_fetch) begin
      if (!req_q)         req_d = 1'b1;
      else if (IMEM_ACK)  req_d = 1'b0;
      else if (tmo_hit)   req_d = 1'b0;
    end else if (enter_fetch && !halt_retire) begin
      req_d = 1'b1;
    end
    if (fetch_ack)       tmo_d = 16'd0;
    else if (fetch_wait) tmo_d = tmo_inc;
  end

  // Architectural registers: IR on ack, PC in EXECUTE, retire counter.
  always_comb begin
    ir_d  = ir_q;
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (fetch_ack && IR_LE) ir_d = IMEM_RDATA;
    if (!halted_q && (stage_q == ST_EXECUTE) && PC_LE)
      pc_d = PC_CONTROL ? ALU_Y : (pc_q + 16'd1);
    if (enter_fetch) cnt_d = cnt_q + 16'd1;
  end

  // Sticky status: only reset clears them.
  always_comb begin
    halted_d = halted_q | tmo_hit | halt_retire;
    ferr_d   = ferr_q | tmo_hit;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage_q  <= ST_FETCH;
      ir_q     <= 16'd0;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      ferr_q   <= 1'b0;
      cnt_q    <= 16'd0;
      tmo_q    <= 16'd0;
    end else begin
      stage_q  <= stage_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      ferr_q   <= ferr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign STAGE       = stage_q;
  assign IR          = ir_q;
  assign PC          = pc_q;
  assign HALTED      = halted_q;
  assign FETCH_ERR   = ferr_q;
  assign INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_lc3_sequencer.sv
// Bench for lc3_sequencer: directed scenarios with literal expectations,
// then randomized decoder/memory behaviour checked every cycle against an
// instruction-level reference model.
module tb_lc3_sequencer;

  localparam logic [1:0] S_DEC = 2'b00, S_EXE = 2'b01, S_WB = 2'b10, S_FET = 2'b11;
  localparam logic [15:0] HALT = 16'hF025;
  localparam int          TMO  = 16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [15:0] IMEM_RDATA = 16'd0;
  logic        IR_LE = 1'b1;
  logic        PC_LE = 1'b0;
  logic        PC_CONTROL = 1'b0;
  logic [15:0] ALU_Y = 16'd0;
  logic        NEXT_STAGE_LE = 1'b0;
  logic [1:0]  NEXT_STAGE = 2'b00;
  logic        DMEM_BUSY = 1'b0;
  logic [1:0]  STAGE;
  logic [15:0] IR, PC, INSTR_COUNT;
  logic        HALTED, FETCH_ERR;

  int n_cmp = 0;
  int n_err = 0;

  lc3_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .IR_LE(IR_LE), .PC_LE(PC_LE),
    .PC_CONTROL(PC_CONTROL), .ALU_Y(ALU_Y), .NEXT_STAGE_LE(NEXT_STAGE_LE),
    .NEXT_STAGE(NEXT_STAGE), .DMEM_BUSY(DMEM_BUSY), .STAGE(STAGE), .IR(IR),
    .PC(PC), .HALTED(HALTED), .FETCH_ERR(FETCH_ERR), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  stage;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] cnt;
    int          waited;   // cycles spent requesting without ack
    logic        req;
    logic        halted;
    logic        ferr;
  } mst_t;

  mst_t m;

  function automatic mst_t m_reset();
    mst_t r;
    r.stage = S_FET; r.ir = 16'd0; r.pc = 16'h3000; r.cnt = 16'd0;
    r.waited = 0; r.req = 1'b0; r.halted = 1'b0; r.ferr = 1'b0;
    return r;
  endfunction

  // One clock of architectural behaviour, described as instruction events.
  function automatic mst_t m_step(mst_t s, logic ack, logic [15:0] rd, logic irle,
                                  logic pcle, logic pcc, logic [15:0] alu,
                                  logic nsle, logic [1:0] ns, logic busy);
    mst_t n = s;
    if (s.halted) return s;
    if (s.stage == S_FET) begin
      if (!s.req) n.req = 1'b1;
      else if (ack) begin
        if (irle) n.ir = rd;
        n.req = 1'b0; n.stage = S_DEC; n.waited = 0;
      end else begin
        n.waited = s.waited + 1;
        if (n.waited == TMO) begin n.req = 1'b0; n.ferr = 1'b1; n.halted = 1'b1; end
      end
      return n;
    end
    if (s.stage == S_DEC) n.stage = nsle ? ns : S_EXE;
    if (s.stage == S_EXE) begin
      if (pcle) n.pc = pcc ? alu : 16'((32'(s.pc) + 1) % 65536);
      n.stage = nsle ? ns : S_WB;
    end
    if (s.stage == S_WB && !busy) begin
      if (s.ir == HALT) begin n.stage = S_FET; n.halted = 1'b1; end
      else n.stage = nsle ? ns : S_FET;
    end
    if (n.stage == S_FET) begin
      n.cnt = 16'((32'(s.cnt) + 1) % 65536);
      if (!n.halted) n.req = 1'b1;
    end
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m <= m_reset();
    else m <= m_step(m, IMEM_ACK, IMEM_RDATA, IR_LE, PC_LE, PC_CONTROL, ALU_Y,
                     NEXT_STAGE_LE, NEXT_STAGE, DMEM_BUSY);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("m_stage", 16'(STAGE), 16'(m.stage));
    chk("m_ir", IR, m.ir);
    chk("m_pc", PC, m.pc);
    chk("m_addr", IMEM_ADDR, m.pc);
    chk("m_req", 16'(IMEM_REQ), 16'(m.req));
    chk("m_halted", 16'(HALTED), 16'(m.halted));
    chk("m_ferr", 16'(FETCH_ERR), 16'(m.ferr));
    chk("m_count", INSTR_COUNT, m.cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stage"}, 16'(STAGE), 16'h0003);
    chk({tag, "_ir"}, IR, 16'h0000);
    chk({tag, "_pc"}, PC, 16'h3000);
    chk({tag, "_req"}, 16'(IMEM_REQ), 16'h0000);
    chk({tag, "_halted"}, 16'(HALTED), 16'h0000);
    chk({tag, "_ferr"}, 16'(FETCH_ERR), 16'h0000);
    chk({tag, "_count"}, INSTR_COUNT, 16'h0000);
  endtask

  // Stay in WRITEBACK while DMEM is busy for `busy` cycles; report WB length.
  task automatic finish_wb(input int busy, output int wbc);
    wbc = 0;
    while (STAGE == S_WB && wbc < 20) begin
      wbc++;
      DMEM_BUSY = (wbc <= busy);
      step();
    end
    DMEM_BUSY = 1'b0;
  endtask

  // From FETCH with REQ high: ack after dly cycles, then DEC/EXE/WB.
  task automatic run_instr(input logic [15:0] rd, input int dly, input logic ple,
                           input logic pcc, input logic [15:0] alu, input int busy,
                           output int wbc);
    for (int i = 0; i < dly; i++) step();
    IMEM_ACK = 1'b1; IMEM_RDATA = rd; step(); IMEM_ACK = 1'b0;
    step();
    PC_LE = ple; PC_CONTROL = pcc; ALU_Y = alu; step();
    PC_LE = 1'b0; PC_CONTROL = 1'b0;
    finish_wb(busy, wbc);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wbc;
    int hcnt;
    int ack_pct;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2 chk_reset_vals("rst");
    step(); step();
    RST_N = 1'b1;
    step();
    chk("first_req", 16'(IMEM_REQ), 16'h0001);

    // 1: ack in first REQ cycle
    IMEM_ACK = 1'b1; IMEM_RDATA = 16'h1262; PC_LE = 1'b1;
    step();
    IMEM_ACK = 1'b0;
    chk("t1_ir", IR, 16'h1262);
    chk("t1_dec", 16'(STAGE), 16'h0000);
    chk("t1_req_low", 16'(IMEM_REQ), 16'h0000);
    step(); chk("t1_exe", 16'(STAGE), 16'h0001);
    step(); chk("t1_wb", 16'(STAGE), 16'h0002); chk("t1_pc", PC, 16'h3001);
    PC_LE = 1'b0;
    step(); chk("t1_fetch", 16'(STAGE), 16'h0003); chk("t1_count", INSTR_COUNT, 16'h0001);

    // 2: ack delayed by 3 cycles -> 4 REQ cycles at a stable address
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", 16'(IMEM_REQ), 16'h0001);
      chk("t2_addr", IMEM_ADDR, 16'h3001);
      chk("t2_ferr", 16'(FETCH_ERR), 16'h0000);
      IMEM_ACK = (i == 3); IMEM_RDATA = 16'h5020;
      step();
    end
    IMEM_ACK = 1'b0;
    chk("t2_req_done", 16'(IMEM_REQ), 16'h0000);
    chk("t2_ir", IR, 16'h5020);

    // 3: jump target, then PC wrap
    step();
    PC_LE = 1'b1; PC_CONTROL = 1'b1; ALU_Y = 16'h4000;
    step();
    PC_LE = 1'b0; PC_CONTROL = 1'b0;
    step();
    chk("t3_addr", IMEM_ADDR, 16'h4000);
    run_instr(16'h1021, 0, 1'b1, 1'b1, 16'hFFFF, 0, wbc);
    chk("t3_pc_ffff", PC, 16'hFFFF);
    run_instr(16'h1021, 1, 1'b1, 1'b0, 16'h0000, 0, wbc);
    chk("t3_pc_wrap", PC, 16'h0000);
    chk("t3_count", INSTR_COUNT, 16'h0004);

    // 4: override EXECUTE -> DECODE, then a 2-cycle DMEM stall
    IMEM_ACK = 1'b1; IMEM_RDATA = 16'h6040; step(); IMEM_ACK = 1'b0;
    step();
    NEXT_STAGE_LE = 1'b1; NEXT_STAGE = S_DEC; step(); NEXT_STAGE_LE = 1'b0;
    chk("t4_override", 16'(STAGE), 16'h0000);
    step(); step();
    finish_wb(2, wbc);
    chk("t4_wb_cycles", 16'(wbc), 16'h0003);
    chk("t4_count", INSTR_COUNT, 16'h0005);

    // 5: halt opcode
    run_instr(HALT, 0, 1'b0, 1'b0, 16'h0000, 0, wbc);
    for (int i = 0; i < 20; i++) begin
      chk("t5_halted", 16'(HALTED), 16'h0001);
      chk("t5_stage", 16'(STAGE), 16'h0003);
      chk("t5_req", 16'(IMEM_REQ), 16'h0000);
      IMEM_ACK = 1'($urandom); NEXT_STAGE_LE = 1'($urandom); PC_LE = 1'($urandom);
      step();
    end
    IMEM_ACK = 1'b0; NEXT_STAGE_LE = 1'b0; PC_LE = 1'b0;
    chk("t5_count", INSTR_COUNT, 16'h0006);

    // 6: fetch timeout, then reset mid-request
    RST_N = 1'b0; #1 chk_reset_vals("t6_rst"); RST_N = 1'b1;
    step();
    for (int i = 0; i < TMO; i++) begin
      chk("t6_req_wait", 16'(IMEM_REQ), 16'h0001);
      chk("t6_ferr_wait", 16'(FETCH_ERR), 16'h0000);
      step();
    end
    chk("t6_ferr", 16'(FETCH_ERR), 16'h0001);
    chk("t6_halted", 16'(HALTED), 16'h0001);
    chk("t6_req_off", 16'(IMEM_REQ), 16'h0000);
    RST_N = 1'b0; #1 RST_N = 1'b1;
    step(); step();
    chk("t6_req_mid", 16'(IMEM_REQ), 16'h0001);
    #1 RST_N = 1'b0;
    #1 chk_reset_vals("t6_async");
    #1 RST_N = 1'b1;
    step();

    // Randomized decoder/memory behaviour; model checks every cycle.
    hcnt = 0;
    for (int c = 0; c < 6000; c++) begin
      ack_pct = (c < 4000) ? 35 : 6;
      IMEM_ACK      = ($urandom_range(0, 99) < ack_pct);
      IMEM_RDATA    = ($urandom_range(0, 9) == 0) ? HALT : 16'($urandom);
      IR_LE         = ($urandom_range(0, 9) != 0);
      PC_LE         = 1'($urandom);
      PC_CONTROL    = 1'($urandom);
      ALU_Y         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      NEXT_STAGE_LE = ($urandom_range(0, 6) == 0);
      NEXT_STAGE    = 2'($urandom);
      DMEM_BUSY     = ($urandom_range(0, 3) == 0);
      if (m.halted) hcnt++; else hcnt = 0;
      if (hcnt > 3 || $urandom_range(0, 499) == 0) begin
        RST_N = 1'b0; #1 RST_N = 1'b1;
        hcnt = 0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
